chroma8x8_mode_select: RTL and testbench

- Consumer side of the chroma 8x8 SAD stage in the IntraPred path.
- Accepts one block's three SADs (V, H, DC) together with the three residual blocks, and picks the intra chroma mode with the minimum SAD.
- Latches only the winning residual block, then streams it row by row (8 samples per beat, 8 beats) to the downstream transform/quant stage over a valid/ready handshake.

---
 rtl/chroma8x8_mode_select_pkg.sv | 21 ++
 rtl/chroma8x8_mode_select_if.sv | 32 +++
 rtl/chroma8x8_mode_select_min3_sel.sv | 29 ++
 rtl/chroma8x8_mode_select.sv | 103 ++++++++++
 tb/tb_chroma8x8_mode_select.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/chroma8x8_mode_select_pkg.sv
// Shared IntraPred definitions: chroma mode encoding, SAD slot indices and sample/row types.
package intrapred_pkg;

  localparam int CHROMA_BLK  = 64;
  localparam int CHROMA_ROWS = 8;

  localparam int SAD_V  = 0;
  localparam int SAD_H  = 1;
  localparam int SAD_DC = 2;

  typedef enum logic [1:0] {
    CHROMA_DC = 2'd0,
    CHROMA_H  = 2'd1,
    CHROMA_V  = 2'd2
  } chroma_mode_e;

  typedef logic signed [7:0] sample_t;
  // Column c of a row lives in element [c].
  typedef sample_t [7:0] row_t;

endpackage

// File: rtl/chroma8x8_mode_select_if.sv
// Block offer from the SAD stage plus the row-beat stream toward transform/quant.
interface chroma8x8_mode_select_if #(
  parameter int SAD_W = 8
);
  import intrapred_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [SAD_W-1:0] sads [3];
  sample_t          vres [CHROMA_BLK];
  sample_t          hres [CHROMA_BLK];
  sample_t          dcres [CHROMA_BLK];

  logic             out_valid;
  logic             out_ready;
  row_t             out_row;
  logic [2:0]       out_row_idx;
  logic             out_last;
  logic [1:0]       out_mode;
  logic [SAD_W-1:0] out_sad;

  modport master (
    output in_valid, sads, vres, hres, dcres, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last, out_mode, out_sad
  );

  modport slave (
    input  in_valid, sads, vres, hres, dcres, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last, out_mode, out_sad
  );

endinterface

// File: rtl/chroma8x8_mode_select_min3_sel.sv
// Combinational minimum-of-three SAD selector with DC > H > V tie priority.
module chroma_min3_sel
  import intrapred_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_sad_v,
  input  logic [W-1:0] i_sad_h,
  input  logic [W-1:0] i_sad_dc,
  output chroma_mode_e o_mode,
  output logic [W-1:0] o_min_sad
);

  always_comb begin
    o_mode    = CHROMA_DC;
    o_min_sad = i_sad_dc;
    // DC wins any tie it is part of; otherwise H wins a tie with V.
    if (!((i_sad_dc <= i_sad_h) && (i_sad_dc <= i_sad_v))) begin
      if (i_sad_h <= i_sad_v) begin
        o_mode    = CHROMA_H;
        o_min_sad = i_sad_h;
      end else begin
        o_mode    = CHROMA_V;
        o_min_sad = i_sad_v;
      end
    end
  end

endmodule

// File: rtl/chroma8x8_mode_select.sv
// Chroma 8x8 intra mode decision: latch the min-SAD residual block and stream it one row per beat.
module chroma8x8_mode_select
  import intrapred_pkg::*;
#(
  parameter int SAD_W = 8,
  parameter int ROWS  = CHROMA_ROWS
) (
  input  logic                        clk,
  input  logic                        reset,
  chroma8x8_mode_select_if.slave      bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]       r_state;
  logic [2:0]       r_row_cnt;
  chroma_mode_e     r_mode;
  logic [SAD_W-1:0] r_sad;
  row_t             r_buf [ROWS];

  chroma_mode_e     w_mode;
  logic [SAD_W-1:0] w_min_sad;
  row_t             w_sel [ROWS];
  logic             w_accept;
  logic             w_beat;
  logic             w_last_row;

  chroma_min3_sel #(.W(SAD_W)) u_min3 (
    .i_sad_v   (bus.sads[SAD_V]),
    .i_sad_h   (bus.sads[SAD_H]),
    .i_sad_dc  (bus.sads[SAD_DC]),
    .o_mode    (w_mode),
    .o_min_sad (w_min_sad)
  );

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_STREAM);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_beat        = bus.out_valid && bus.out_ready;
  assign w_last_row    = (r_row_cnt == 3'(ROWS - 1));

  assign bus.out_row     = bus.out_valid ? r_buf[r_row_cnt] : '0;
  assign bus.out_row_idx = r_row_cnt;
  assign bus.out_last    = bus.out_valid && w_last_row;
  assign bus.out_mode    = r_mode;
  assign bus.out_sad     = r_sad;

  // Only the winning block is captured; the other two are never stored.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      always_comb begin
        w_sel[gi] = '0;
        for (int c = 0; c < 8; c++) begin
          case (w_mode)
            CHROMA_DC: w_sel[gi][c] = bus.dcres[gi*8 + c];
            CHROMA_H:  w_sel[gi][c] = bus.hres[gi*8 + c];
            default:   w_sel[gi][c] = bus.vres[gi*8 + c];
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_buf[gi] <= w_sel[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_row_cnt <= 3'd0;
      r_mode    <= CHROMA_DC;
      r_sad     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mode    <= w_mode;
            r_sad     <= w_min_sad;
            r_row_cnt <= 3'd0;
            r_state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_beat) begin
            if (w_last_row) begin
              r_row_cnt <= 3'd0;
              r_state   <= ST_IDLE;
            end else begin
              r_row_cnt <= r_row_cnt + 3'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chroma8x8_mode_select.sv
// Self-checking bench: directed vector table, back-to-back, mid-stream reset and randomized blocks.
module tb_chroma8x8_mode_select;
  import intrapred_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  chroma8x8_mode_select_if #(.SAD_W(8)) bus();

  chroma8x8_mode_select #(.SAD_W(8), .ROWS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [7:0] tv [64];
  logic signed [7:0] th [64];
  logic signed [7:0] td [64];
  logic signed [7:0] exp_blk [64];

  typedef struct {
    int v; int h; int d;
    int fill;
    int stall;
    int exp_mode;
    int exp_sad;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
  endtask

  // Reference: smallest SAD wins, ties go DC first, then H, then V.
  function automatic int ref_sad(int v, int h, int d);
    int m;
    m = v;
    if (h < m) m = h;
    if (d < m) m = d;
    return m;
  endfunction

  function automatic int ref_mode(int v, int h, int d);
    int m;
    m = ref_sad(v, h, d);
    if (d == m) return 0;
    if (h == m) return 1;
    return 2;
  endfunction

  task automatic fill_block(input int fill);
    for (int i = 0; i < 64; i++) begin
      tv[i] = 8'($urandom_range(0, 255));
      th[i] = 8'($urandom_range(0, 255));
      td[i] = 8'($urandom_range(0, 255));
      if (fill == 1) th[i] = 8'(i - 32);
      if (fill == 2) tv[i] = 8'sh80;
      bus.vres[i]  = tv[i];
      bus.hres[i]  = th[i];
      bus.dcres[i] = td[i];
    end
  endtask

  task automatic set_sads(input int v, input int h, input int d);
    bus.sads[0] = 8'(v);
    bus.sads[1] = 8'(h);
    bus.sads[2] = 8'(d);
  endtask

  task automatic snapshot(input int mode);
    for (int i = 0; i < 64; i++)
      exp_blk[i] = (mode == 0) ? td[i] : (mode == 1) ? th[i] : tv[i];
  endtask

  task automatic accept(input bit keep_valid, output int acc);
    int w;
    w = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    acc = cyc_cnt;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Called 1 time unit after the acceptance edge; collects 8 beats.
  task automatic stream_check(input int em, input int es, input int stall);
    int beats;
    int cyc;
    logic [63:0] er;
    beats = 0;
    cyc   = 0;
    while (beats < 8 && cyc < 200) begin
      bus.out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      for (int c = 0; c < 8; c++) er[c*8 +: 8] = exp_blk[beats*8 + c];
      check("out_valid", 64'(bus.out_valid), 64'd1);
      check("in_ready_busy", 64'(bus.in_ready), 64'd0);
      check("row_idx", 64'(bus.out_row_idx), 64'(beats));
      check("row_data", 64'(bus.out_row), er);
      check("last", 64'(bus.out_last), 64'(beats == 7));
      check("mode", 64'(bus.out_mode), 64'(em));
      check("sad", 64'(bus.out_sad), 64'(es));
      if (bus.out_ready) beats++;
      @(posedge clk); #1;
      cyc++;
    end
    check("beat_count", 64'(beats), 64'd8);
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_ready", 64'(bus.in_ready), 64'd1);
    check("idle_mode", 64'(bus.out_mode), 64'(em));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int acc_a;
    int acc_b;
    int v, h, d, r, em, es;

    vecs[0] = '{40, 25, 60, 1, 0, 1, 25};
    vecs[1] = '{17, 17, 17, 0, 0, 0, 17};
    vecs[2] = '{5, 5, 9, 0, 0, 1, 5};
    vecs[3] = '{40, 25, 60, 1, 1, 1, 25};
    vecs[4] = '{0, 255, 255, 2, 0, 2, 0};
    vecs[5] = '{9, 3, 3, 0, 2, 0, 3};
    vecs[6] = '{1, 2, 3, 0, 1, 2, 1};
    vecs[7] = '{200, 100, 150, 0, 0, 1, 100};
    vecs[8] = '{7, 8, 7, 0, 2, 0, 7};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_sads(0, 0, 0);
    fill_block(0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_row_idx", 64'(bus.out_row_idx), 64'd0);
    check("rst_mode", 64'(bus.out_mode), 64'd0);
    check("rst_sad", 64'(bus.out_sad), 64'd0);
    check("rst_row", 64'(bus.out_row), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 9; k++) begin
      fill_block(vecs[k].fill);
      set_sads(vecs[k].v, vecs[k].h, vecs[k].d);
      accept(1'b0, acc_a);
      snapshot(vecs[k].exp_mode);
      if (vecs[k].fill == 1 && vecs[k].exp_mode == 1)
        check("ramp_row0", 64'(bus.out_row), 64'hE7E6E5E4E3E2E1E0);
      if (vecs[k].fill == 2 && vecs[k].exp_mode == 2)
        check("neg128_row0", 64'(bus.out_row), 64'h8080808080808080);
      stream_check(vecs[k].exp_mode, vecs[k].exp_sad, vecs[k].stall);
    end

    // Back-to-back: second offer held high during the first stream.
    fill_block(0);
    set_sads(30, 40, 50);
    accept(1'b1, acc_a);
    snapshot(2);
    fill_block(0);
    set_sads(90, 12, 12);
    stream_check(2, 30, 0);
    accept(1'b0, acc_b);
    check("b2b_period", 64'(acc_b - acc_a), 64'd9);
    snapshot(0);
    stream_check(0, 12, 0);

    // Reset asserted after row 3 has been handed over.
    fill_block(0);
    set_sads(10, 20, 30);
    accept(1'b0, acc_a);
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("pre_rst_idx", 64'(bus.out_row_idx), 64'd4);
    reset = 1'b0;
    #1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_idx", 64'(bus.out_row_idx), 64'd0);
    check("midrst_mode", 64'(bus.out_mode), 64'd0);
    check("midrst_sad", 64'(bus.out_sad), 64'd0);
    bus.out_ready = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    fill_block(0);
    set_sads(50, 5, 50);
    accept(1'b0, acc_a);
    snapshot(1);
    stream_check(1, 5, 0);

    // Randomized blocks with forced ties and random backpressure.
    for (int k = 0; k < 30; k++) begin
      v = $urandom_range(0, 255);
      h = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      r = $urandom_range(0, 4);
      if (r == 0) h = v;
      if (r == 1) d = h;
      if (r == 2) d = v;
      if (r == 3) begin h = v; d = v; end
      em = ref_mode(v, h, d);
      es = ref_sad(v, h, d);
      fill_block(0);
      set_sads(v, h, d);
      accept(1'b0, acc_a);
      snapshot(em);
      stream_check(em, es, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
